line_sel_decoder: RTL

LINE_SEL_DECODER -- requirements
Module: line_sel_decoder

---
 rtl/line_sel_pkg.sv | 14 +
 rtl/onehot_dec.sv | 19 +
 rtl/line_sel_decoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/line_sel_pkg.sv
// Shared definitions for the line select decoder: FSM state encoding and
// default geometry constants.
package line_sel_pkg;

    localparam int ADDR_W_DEF    = 7;
    localparam int NUM_LINES_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index to one-hot decoder. Indices at or beyond NUM_LINES
// decode to all-zero, so callers get range checking for free.
module onehot_dec #(
    parameter int IDX_W     = 7,
    parameter int NUM_LINES = 128
) (
    input  logic [IDX_W-1:0]     idx,
    output logic [NUM_LINES-1:0] onehot
);

    // One comparator per line; an out-of-range index matches none of them.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/line_sel_decoder.sv
// Registered one-hot line select with single-line requests and a full
// in-order sweep of every line. Optional out-of-range error pulse is built
// only when LINE_SEL_ERR_EN is defined.
module line_sel_decoder
    import line_sel_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_LINES = NUM_LINES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic                 sweep_start,
    output logic [NUM_LINES-1:0] sel,
    output logic                 sel_valid,
    output logic                 busy,
`ifdef LINE_SEL_ERR_EN
    output logic                 err,
`endif
    output logic                 sweep_done
);

    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NUM_LINES - 1);

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     cnt, cnt_nxt;
    logic                  pending, pending_nxt;
    logic                  req_take;
    logic [ADDR_W-1:0]     dec_idx;
    logic [NUM_LINES-1:0]  dec_oh;
    logic [NUM_LINES-1:0]  sel_nxt;
    logic                  sel_valid_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
`ifdef LINE_SEL_ERR_EN
    logic                  err_nxt;
`endif

    // A request is only honoured in IDLE with no sweep queued behind it.
    assign req_take = (state == ST_IDLE) && !pending && req_valid;

    // The single decoder serves either the sweep counter or the request.
    assign dec_idx = (state_nxt == ST_SWEEP) ? cnt_nxt : req_addr;

    onehot_dec #(
        .IDX_W     (ADDR_W),
        .NUM_LINES (NUM_LINES)
    ) u_dec (
        .idx    (dec_idx),
        .onehot (dec_oh)
    );

    // State, sweep counter and queued-sweep flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
        end
    end

    // Next-state logic; a sweep requested alongside a request waits one cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_nxt   = ST_SWEEP;
                    cnt_nxt     = '0;
                    pending_nxt = 1'b0;
                end else if (sweep_start) begin
                    if (req_valid) begin
                        pending_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_SWEEP;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_SWEEP: begin
                if (cnt == LAST_LINE) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt   = ST_IDLE;
                cnt_nxt     = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is going.
    always_comb begin
        sel_nxt       = '0;
        sel_valid_nxt = 1'b0;
        if (state_nxt == ST_SWEEP) begin
            sel_nxt       = dec_oh;
            sel_valid_nxt = 1'b1;
        end else if (req_take) begin
            sel_nxt       = dec_oh;
            sel_valid_nxt = |dec_oh;
        end
        busy_nxt = (state_nxt != ST_IDLE) || pending_nxt;
        done_nxt = (state_nxt == ST_DONE);
`ifdef LINE_SEL_ERR_EN
        err_nxt  = req_take && !(|dec_oh);
`endif
    end

    // Registered outputs, cleared asynchronously so a sweep cannot linger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
`ifdef LINE_SEL_ERR_EN
            err        <= 1'b0;
`endif
        end else begin
            sel        <= sel_nxt;
            sel_valid  <= sel_valid_nxt;
            busy       <= busy_nxt;
            sweep_done <= done_nxt;
`ifdef LINE_SEL_ERR_EN
            err        <= err_nxt;
`endif
        end
    end

endmodule
